// File: rtl/hls_seq_pkg.sv
// Shared offsets, states and helpers for the HLS test sequencer.
// Optional poll timeout is enabled by defining HLS_SEQ_TIMEOUT_EN.
package hls_seq_pkg;
  localparam logic [31:0] REG_AP_CTRL   = 32'h00;
  localparam logic [31:0] REG_ERR_NUM   = 32'h10;
  localparam logic [31:0] REG_FRAME_NUM = 32'h20;
  localparam logic [31:0] REG_FRAME_OFS = 32'h28;
  localparam int          AP_IDLE_BIT   = 2;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    S_OFS, S_START, S_DONE
  } src_state_t;

  typedef enum logic [2:0] {
    C_WAIT, C_NUM, C_START, C_POLL,
    C_GAP, C_ERR, C_ACC
  } chk_state_t;

  typedef enum logic [2:0] {
    M_IDLE, M_WR, M_WB, M_RA, M_RR
  } mst_state_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/hls_test_sequencer_if.sv
// AXI-Lite bundle between the sequencer and one HLS ctrl port.
// Optional poll timeout is enabled by defining HLS_SEQ_TIMEOUT_EN.
interface hls_test_sequencer_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hls_test_sequencer_axil_single_master.sv
// One-outstanding AXI-Lite master; done pulses on the B or R handshake.
// Optional poll timeout is enabled by defining HLS_SEQ_TIMEOUT_EN.
module axil_single_master
  import hls_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  hls_test_sequencer_if.master m
);
  mst_state_t  r_st, w_nxt;
  logic        r_awvalid, r_wvalid, r_bready;
  logic        r_arvalid, r_rready;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      M_IDLE: if (req) w_nxt = we ? M_WR : M_RA;
      M_WR: begin
        if ((!r_awvalid || m.awready) &&
            (!r_wvalid || m.wready))
          w_nxt = M_WB;
      end
      M_WB: if (m.bvalid) w_nxt = M_IDLE;
      M_RA: if (m.arready) w_nxt = M_RR;
      M_RR: if (m.rvalid) w_nxt = M_IDLE;
      default: w_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= M_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= 4'hF;
    end else begin
      r_st <= w_nxt;
      unique case (r_st)
        M_IDLE: begin
          if (req) begin
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_wstrb   <= wstrb;
            r_awvalid <= we;
            r_wvalid  <= we;
            r_arvalid <= !we;
          end
        end
        M_WR: begin
          if (m.awready) r_awvalid <= 1'b0;
          if (m.wready)  r_wvalid  <= 1'b0;
          if (w_nxt == M_WB) r_bready <= 1'b1;
        end
        M_WB: if (m.bvalid) r_bready <= 1'b0;
        M_RA: begin
          if (m.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        M_RR: if (m.rvalid) r_rready <= 1'b0;
        default: ;
      endcase
    end
  end

  assign m.awaddr  = r_addr;
  assign m.araddr  = r_addr;
  assign m.wdata   = r_wdata;
  assign m.wstrb   = r_wstrb;
  assign m.awvalid = r_awvalid;
  assign m.wvalid  = r_wvalid;
  assign m.bready  = r_bready;
  assign m.arvalid = r_arvalid;
  assign m.rready  = r_rready;

  assign done  = (r_st == M_WB && m.bvalid) ||
                 (r_st == M_RR && m.rvalid);
  assign rdata = m.rdata;
  assign resp  = (r_st == M_WB) ? m.bresp : m.rresp;
endmodule

// File: rtl/hls_test_sequencer.sv
// Sequences the HLS frame source once, then loops the frame checker.
// Optional poll timeout is enabled by defining HLS_SEQ_TIMEOUT_EN.
module hls_test_sequencer
  import hls_seq_pkg::*;
#(
  parameter int FRAME_OFFSET   = 3742,
  parameter int TEST_FRAME_NUM = 10,
  parameter int POLL_GAP       = 16
`ifdef HLS_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC  = 2**24
`endif
) (
  input  logic        clk_0,
  input  logic        sync_rst_0,
  input  logic        enable,
  hls_test_sequencer_if.master m0,
  hls_test_sequencer_if.master m1,
  output logic [31:0] acc_error_num,
  output logic [31:0] acc_frame_num,
  output logic        iter_done,
  output logic        src_started,
  output logic        resp_err,
  output logic        timeout
);
  src_state_t  r_src, w_src_nxt;
  chk_state_t  r_chk, w_chk_nxt;
  logic        w_req0, w_done0, w_req1, w_we1, w_done1;
  logic [31:0] w_addr0, w_wdata0, w_rdata0;
  logic [31:0] w_addr1, w_wdata1, w_rdata1;
  logic [3:0]  w_wstrb0, w_wstrb1;
  logic [1:0]  w_resp0, w_resp1;
  logic [31:0] r_gap, r_err_val, r_acc_err, r_acc_frm;
  logic        r_started, r_resp_err, w_to_hit, w_polling;

  assign w_req0   = (r_src != S_DONE);
  assign w_addr0  = (r_src == S_OFS) ? REG_FRAME_OFS : REG_AP_CTRL;
  assign w_wdata0 = (r_src == S_OFS) ? 32'(FRAME_OFFSET) : 32'd1;
  assign w_wstrb0 = (r_src == S_OFS) ? 4'hF : 4'h1;

  always_comb begin
    w_src_nxt = r_src;
    unique case (r_src)
      S_OFS:   if (w_done0) w_src_nxt = S_START;
      S_START: if (w_done0) w_src_nxt = S_DONE;
      default: w_src_nxt = S_DONE;
    endcase
  end

  // Checker bus request decode; the engine latches these on acceptance.
  always_comb begin
    w_req1   = 1'b0;
    w_we1    = 1'b0;
    w_addr1  = REG_AP_CTRL;
    w_wdata1 = 32'd1;
    w_wstrb1 = 4'hF;
    unique case (1'b1)
      (r_chk == C_NUM): begin
        w_req1   = 1'b1;
        w_we1    = 1'b1;
        w_addr1  = REG_FRAME_NUM;
        w_wdata1 = 32'(TEST_FRAME_NUM);
      end
      (r_chk == C_START): begin
        w_req1   = 1'b1;
        w_we1    = 1'b1;
        w_wstrb1 = 4'h1;
      end
      (r_chk == C_POLL): w_req1 = 1'b1;
      (r_chk == C_ERR): begin
        w_req1  = 1'b1;
        w_addr1 = REG_ERR_NUM;
      end
      default: ;
    endcase
  end

  assign w_polling = (r_chk == C_POLL) || (r_chk == C_GAP);

  always_comb begin
    w_chk_nxt = r_chk;
    unique case (r_chk)
      C_WAIT:  if (r_started && enable) w_chk_nxt = C_NUM;
      C_NUM:   if (w_done1) w_chk_nxt = C_START;
      C_START: if (w_done1) w_chk_nxt = C_POLL;
      C_POLL: begin
        if (w_done1)
          w_chk_nxt = (w_rdata1[AP_IDLE_BIT] || w_to_hit) ?
                      C_ERR : C_GAP;
      end
      C_GAP: begin
        if (w_to_hit)
          w_chk_nxt = C_ERR;
        else if (r_gap == 32'(POLL_GAP - 1))
          w_chk_nxt = C_POLL;
      end
      C_ERR:   if (w_done1) w_chk_nxt = C_ACC;
      default: w_chk_nxt = C_WAIT;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (sync_rst_0) begin
      r_src      <= S_OFS;
      r_chk      <= C_WAIT;
      r_started  <= 1'b0;
      r_resp_err <= 1'b0;
      r_gap      <= '0;
      r_err_val  <= '0;
      r_acc_err  <= '0;
      r_acc_frm  <= '0;
    end else begin
      r_src <= w_src_nxt;
      r_chk <= w_chk_nxt;
      if (r_src == S_START && w_done0) r_started <= 1'b1;
      if ((w_done0 && w_resp0 != RESP_OKAY) ||
          (w_done1 && w_resp1 != RESP_OKAY))
        r_resp_err <= 1'b1;
      r_gap <= (r_chk == C_GAP) ? r_gap + 32'd1 : '0;
      if (r_chk == C_ERR && w_done1) r_err_val <= w_rdata1;
      if (r_chk == C_ACC) begin
        r_acc_err <= sat_add(r_acc_err, r_err_val);
        r_acc_frm <= sat_add(r_acc_frm, 32'(TEST_FRAME_NUM));
      end
    end
  end

`ifdef HLS_SEQ_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_timeout;

  // Counter holds at the limit so a mid-poll read can finish first.
  assign w_to_hit = (r_to_cnt == 32'(TIMEOUT_CYC));

  always_ff @(posedge clk_0) begin
    if (sync_rst_0) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_polling)
        r_to_cnt <= '0;
      else if (!w_to_hit)
        r_to_cnt <= r_to_cnt + 32'd1;
      if (w_polling && w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  axil_single_master u_m0 (
    .clk   (clk_0),
    .rst   (sync_rst_0),
    .req   (w_req0),
    .we    (1'b1),
    .addr  (w_addr0),
    .wdata (w_wdata0),
    .wstrb (w_wstrb0),
    .done  (w_done0),
    .rdata (w_rdata0),
    .resp  (w_resp0),
    .m     (m0)
  );

  axil_single_master u_m1 (
    .clk   (clk_0),
    .rst   (sync_rst_0),
    .req   (w_req1),
    .we    (w_we1),
    .addr  (w_addr1),
    .wdata (w_wdata1),
    .wstrb (w_wstrb1),
    .done  (w_done1),
    .rdata (w_rdata1),
    .resp  (w_resp1),
    .m     (m1)
  );

  assign acc_error_num = r_acc_err;
  assign acc_frame_num = r_acc_frm;
  assign iter_done     = (r_chk == C_ACC);
  assign src_started   = r_started;
  assign resp_err      = r_resp_err;
endmodule

// File: tb/tb_hls_test_sequencer.sv
// Directed bench: AXI-Lite slave models for the source and checker ports.
// Defining HLS_SEQ_TIMEOUT_EN switches the timeout step to the enabled build.
module tb_hls_test_sequencer;
  localparam int POLL_GAP = 16;

  logic clk_0 = 1'b0;
  logic sync_rst_0 = 1'b1;
  logic enable = 1'b1;
  logic [31:0] acc_error_num, acc_frame_num;
  logic iter_done, src_started, resp_err, timeout;

  hls_test_sequencer_if s0();
  hls_test_sequencer_if s1();

  hls_test_sequencer #(
    .FRAME_OFFSET   (3742),
    .TEST_FRAME_NUM (10),
    .POLL_GAP       (POLL_GAP)
`ifdef HLS_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC  (200)
`endif
  ) dut (
    .clk_0         (clk_0),
    .sync_rst_0    (sync_rst_0),
    .enable        (enable),
    .m0            (s0),
    .m1            (s1),
    .acc_error_num (acc_error_num),
    .acc_frame_num (acc_frame_num),
    .iter_done     (iter_done),
    .src_started   (src_started),
    .resp_err      (resp_err),
    .timeout       (timeout)
  );

  always #5 clk_0 = ~clk_0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_iter = 0;

  always @(posedge clk_0) cyc <= cyc + 1;
  always @(posedge clk_0)
    if (!sync_rst_0 && iter_done) n_iter <= n_iter + 1;

  // Port 0 slave: always ready, never read.
  logic [67:0] p0_log[$];
  logic        p0_aw_got = 0, p0_w_got = 0;
  logic [31:0] p0_aw_a, p0_w_d;
  logic [3:0]  p0_w_s;
  int          p0_ar_cnt = 0;

  assign s0.awready = 1'b1;
  assign s0.wready  = 1'b1;
  assign s0.arready = 1'b1;
  assign s0.rvalid  = 1'b0;
  assign s0.rdata   = 32'd0;
  assign s0.rresp   = 2'b00;
  assign s0.bresp   = 2'b00;

  always @(posedge clk_0) begin
    if (sync_rst_0) begin
      s0.bvalid <= 1'b0;
      p0_aw_got <= 1'b0;
      p0_w_got  <= 1'b0;
    end else begin
      if (s0.arvalid) p0_ar_cnt <= p0_ar_cnt + 1;
      if (s0.awvalid) begin
        p0_aw_got <= 1'b1;
        p0_aw_a   <= s0.awaddr;
      end
      if (s0.wvalid) begin
        p0_w_got <= 1'b1;
        p0_w_d   <= s0.wdata;
        p0_w_s   <= s0.wstrb;
      end
      if (p0_aw_got && p0_w_got && !s0.bvalid) s0.bvalid <= 1'b1;
      if (s0.bvalid && s0.bready) begin
        s0.bvalid <= 1'b0;
        p0_aw_got <= 1'b0;
        p0_w_got  <= 1'b0;
        p0_log.push_back({p0_aw_a, p0_w_d, p0_w_s});
      end
    end
  end

  // Port 1 slave: behavioural HLS checker control registers.
  logic [67:0] p1_log[$];
  int          p1_aw_delay = 0;
  int          p1_idle_after = 3;
  logic [31:0] p1_err_val = 32'd5;
  logic        p1_berr = 1'b0;
  logic        p1_aw_got = 0, p1_w_got = 0, p1_ar_busy = 0;
  logic        p1_aw_pend = 0, p1_w_pend = 0, p1_wfirst = 0;
  logic [31:0] p1_aw_a, p1_w_d, p1_ar_a;
  logic [3:0]  p1_w_s;
  int          p1_aw_wait = 0, p1_polls = 0, p1_last_poll = 0;
  int          p1_gap_viol = 0, p1_viol = 0, p1_ar_cnt = 0;
  int          p1_err_rd = 0, p1_err_cyc = 0;

  always @(posedge clk_0) begin
    if (sync_rst_0) begin
      s1.awready <= 1'b0;
      s1.wready  <= 1'b0;
      s1.bvalid  <= 1'b0;
      s1.bresp   <= 2'b00;
      s1.arready <= 1'b0;
      s1.rvalid  <= 1'b0;
      s1.rdata   <= 32'd0;
      s1.rresp   <= 2'b00;
      p1_aw_got  <= 1'b0;
      p1_w_got   <= 1'b0;
      p1_ar_busy <= 1'b0;
      p1_aw_wait <= 0;
    end else begin
      p1_aw_pend <= s1.awvalid && !s1.awready;
      p1_w_pend  <= s1.wvalid && !s1.wready;
      if (p1_aw_pend && !s1.awvalid) p1_viol <= p1_viol + 1;
      if (p1_w_pend && !s1.wvalid) p1_viol <= p1_viol + 1;
      if (s1.bready && !(p1_aw_got && p1_w_got))
        p1_viol <= p1_viol + 1;
      if (s1.awvalid && !s1.wvalid) p1_wfirst <= 1'b1;
      if (s1.awvalid && s1.awready) begin
        p1_aw_got  <= 1'b1;
        p1_aw_a    <= s1.awaddr;
        s1.awready <= 1'b0;
        p1_aw_wait <= 0;
      end else if (s1.awvalid && !p1_aw_got) begin
        if (p1_aw_wait >= p1_aw_delay) s1.awready <= 1'b1;
        else p1_aw_wait <= p1_aw_wait + 1;
      end
      if (s1.wvalid && s1.wready) begin
        p1_w_got  <= 1'b1;
        p1_w_d    <= s1.wdata;
        p1_w_s    <= s1.wstrb;
        s1.wready <= 1'b0;
      end else if (s1.wvalid && !p1_w_got) begin
        s1.wready <= 1'b1;
      end
      if (p1_aw_got && p1_w_got && !s1.bvalid) begin
        s1.bvalid <= 1'b1;
        s1.bresp  <= (p1_berr && p1_aw_a == 32'h0) ? 2'b10 : 2'b00;
      end
      if (s1.bvalid && s1.bready) begin
        s1.bvalid <= 1'b0;
        p1_aw_got <= 1'b0;
        p1_w_got  <= 1'b0;
        p1_log.push_back({p1_aw_a, p1_w_d, p1_w_s});
        if (p1_aw_a == 32'h0) p1_polls <= 0;
      end
      if (s1.rvalid && s1.rready) begin
        s1.rvalid  <= 1'b0;
        p1_ar_busy <= 1'b0;
        if (p1_ar_a == 32'h10) begin
          p1_err_rd  <= p1_err_rd + 1;
          p1_err_cyc <= cyc;
        end
      end
      if (s1.arvalid && s1.arready) begin
        s1.arready <= 1'b0;
        p1_ar_busy <= 1'b1;
        p1_ar_a    <= s1.araddr;
        p1_ar_cnt  <= p1_ar_cnt + 1;
        s1.rvalid  <= 1'b1;
        if (s1.araddr == 32'h0) begin
          s1.rdata <= (p1_polls + 1 >= p1_idle_after) ? 32'h4 : 32'h0;
          p1_polls <= p1_polls + 1;
          if (p1_polls != 0 && cyc - p1_last_poll < POLL_GAP)
            p1_gap_viol <= p1_gap_viol + 1;
          p1_last_poll <= cyc;
        end else begin
          s1.rdata <= (s1.araddr == 32'h10) ? p1_err_val : 32'h0;
        end
      end else if (s1.arvalid && !p1_ar_busy) begin
        s1.arready <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the C_ACC cycle, parks the loop, then lets acc settle.
  task automatic wait_iter(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_0);
      if (iter_done) seen = 1;
    end
    chk(tag, 68'(seen), 68'd1);
    if (seen) chk({tag, "_lat"}, 68'(cyc - p1_err_cyc), 68'd1);
    enable = 1'b0;
    @(posedge clk_0);
    @(negedge clk_0);
  endtask

  initial begin
    int n_log, n_ar, n_poll;
    bit ok;
    repeat (3) @(posedge clk_0);
    @(negedge clk_0);
    chk("rst_valids",
        68'({s0.awvalid, s0.wvalid, s0.bready, s0.arvalid, s0.rready,
             s1.awvalid, s1.wvalid, s1.bready, s1.arvalid, s1.rready}),
        68'd0);
    chk("rst_wstrb_addr", {s0.wstrb, s1.wstrb, s1.awaddr, s0.awaddr},
        {4'hF, 4'hF, 32'h0, 32'h0});
    chk("rst_acc", 68'({acc_error_num, acc_frame_num}), 68'd0);
    chk("rst_flags", 68'({iter_done, src_started, resp_err, timeout}),
        68'd0);
    sync_rst_0 = 1'b0;

    // Source programming, checker iteration 1 (idle on 3rd poll, err 5).
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_0);
      if (src_started) ok = 1;
    end
    chk("src_started", 68'(ok), 68'd1);
    chk("p0_nwr", 68'(p0_log.size()), 68'd2);
    if (p0_log.size() >= 2) begin
      chk("p0_wr_ofs", p0_log[0], {32'h28, 32'd3742, 4'hF});
      chk("p0_wr_start", p0_log[1], {32'h0, 32'd1, 4'h1});
    end
    wait_iter("iter1", 3000);
    chk("iter1_acc", 68'({acc_error_num, acc_frame_num}),
        68'({32'd5, 32'd10}));
    chk("iter1_count", 68'(n_iter), 68'd1);
    chk("iter1_nwr", 68'(p1_log.size()), 68'd2);
    if (p1_log.size() >= 2) begin
      chk("p1_wr_num", p1_log[0], {32'h20, 32'd10, 4'hF});
      chk("p1_wr_start", p1_log[1], {32'h0, 32'd1, 4'h1});
    end
    chk("iter1_polls", 68'(p1_polls), 68'd3);
    chk("poll_gap", 68'(p1_gap_viol), 68'd0);
    chk("iter1_errrd", 68'(p1_err_rd), 68'd1);
    chk("no_resp_err", 68'(resp_err), 68'd0);

    // Late awready; error count near full scale.
    p1_aw_delay = 4;
    p1_idle_after = 1;
    p1_err_val = 32'hFFFF_FFF0;
    enable = 1'b1;
    wait_iter("iter2", 3000);
    chk("iter2_acc", 68'({acc_error_num, acc_frame_num}),
        68'({32'hFFFF_FFF5, 32'd20}));
    chk("iter2_nwr", 68'(p1_log.size()), 68'd4);
    if (p1_log.size() >= 4) begin
      chk("iter2_wr_num", p1_log[2], {32'h20, 32'd10, 4'hF});
      chk("iter2_wr_start", p1_log[3], {32'h0, 32'd1, 4'h1});
    end
    chk("w_drops_first", 68'(p1_wfirst), 68'd1);
    chk("hs_protocol", 68'(p1_viol), 68'd0);

    // Saturation.
    p1_aw_delay = 0;
    enable = 1'b1;
    wait_iter("iter3", 3000);
    chk("iter3_acc", 68'({acc_error_num, acc_frame_num}),
        68'({32'hFFFF_FFFF, 32'd30}));

    // Error response on start, enable dropped mid-poll.
    p1_berr = 1'b1;
    p1_idle_after = 4;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk_0);
      if (p1_polls >= 2) ok = 1;
    end
    chk("iter4_polling", 68'(ok), 68'd1);
    chk("resp_err_set", 68'(resp_err), 68'd1);
    enable = 1'b0;
    wait_iter("iter4", 3000);
    chk("iter4_acc", 68'({acc_error_num, acc_frame_num}),
        68'({32'hFFFF_FFFF, 32'd40}));
    chk("iter4_polls", 68'(p1_polls), 68'd4);
    n_log = p1_log.size();
    n_ar = p1_ar_cnt;
    repeat (300) @(negedge clk_0);
    chk("parked_quiet",
        68'({16'(p1_log.size() - n_log), 16'(p1_ar_cnt - n_ar)}),
        68'd0);
    chk("parked_iters", 68'(n_iter), 68'd4);

    // Checker never reports idle.
    p1_berr = 1'b0;
    p1_idle_after = 1000000;
    n_poll = p1_ar_cnt;
    enable = 1'b1;
`ifdef HLS_SEQ_TIMEOUT_EN
    wait_iter("iter5_timeout", 2000);
    chk("timeout_set", 68'(timeout), 68'd1);
    chk("timeout_errrd", 68'(p1_err_rd), 68'd5);
    chk("timeout_frames", 68'(acc_frame_num), 68'd50);
`else
    repeat (600) @(negedge clk_0);
    enable = 1'b0;
    chk("timeout_low", 68'(timeout), 68'd0);
    chk("still_polling", 68'(p1_polls >= 10), 68'd1);
    chk("no_iter5", 68'(n_iter), 68'd4);
    chk("no_poll_gap_err", 68'(p1_gap_viol), 68'd0);
    n_poll = p1_ar_cnt - n_poll;
    chk("poll_reads", 68'(n_poll > 10), 68'd1);
`endif

    chk("p0_silent", 68'({16'(p0_log.size()), 16'(p0_ar_cnt)}),
        68'({16'd2, 16'd0}));
    chk("hs_protocol_end", 68'(p1_viol), 68'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
